// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the run/step/halt sequencer: state encoding, counter width, edge pulses.
package cpu_run_ctrl_pkg;

   localparam int unsigned STATE_W   = 2;
   localparam int unsigned CNT_W_DEF = 32;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_HALT  = 2'b11
   } run_state_e;

   typedef struct packed {
      logic start;
      logic go;
      logic step;
   } run_pulse_t;

endpackage

// File: rtl/cpu_run_ctrl_edge_pulse.sv
// Rising-edge detector: one-cycle pulse when d goes 0->1 (d already synchronous to clk).
module cpu_run_ctrl_edge_pulse (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (rst) d_q <= 1'b0;
      else     d_q <= d;
   end

   assign pulse = d & ~d_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle core: owns the PC/regfile/RAM write
// enable, handles ecall halt, single-step and go-resume, and keeps perf counters.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               go,
   input  logic               step,
   input  logic               mode_step,
   input  logic               halt_req,
   input  logic               branch_taken,
   output logic               cpu_en,
   output logic [STATE_W-1:0] state,
   output logic               halted,
   output logic [CNT_W-1:0]   cycles,
   output logic [CNT_W-1:0]   instret,
   output logic [CNT_W-1:0]   branches
);

   run_state_e state_q;
   run_state_e state_d;
   run_pulse_t pls;

   cpu_run_ctrl_edge_pulse u_start_pulse (.clk(clk), .rst(rst), .d(start), .pulse(pls.start));
   cpu_run_ctrl_edge_pulse u_go_pulse    (.clk(clk), .rst(rst), .d(go),    .pulse(pls.go));
   cpu_run_ctrl_edge_pulse u_step_pulse  (.clk(clk), .rst(rst), .d(step),  .pulse(pls.step));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // halt_req wins over every other request, including a coincident step in PAUSE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (pls.start) state_d = mode_step ? S_PAUSE : S_RUN;
         end
         S_RUN: begin
            if (halt_req)       state_d = S_HALT;
            else if (mode_step) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (halt_req)        state_d = S_HALT;
            else if (!mode_step) state_d = S_RUN;
         end
         S_HALT: begin
            if (pls.go) state_d = mode_step ? S_PAUSE : S_RUN;
         end
      endcase
   end

   // go in HALT retires the ecall itself so the PC steps past it
   always_comb begin
      cpu_en = 1'b0;
      case (state_q)
         S_IDLE:  cpu_en = 1'b0;
         S_RUN:   cpu_en = ~halt_req;
         S_PAUSE: cpu_en = pls.step & ~halt_req;
         S_HALT:  cpu_en = pls.go;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         halted   <= 1'b0;
         cycles   <= '0;
         instret  <= '0;
         branches <= '0;
      end else begin
         halted   <= (state_d == S_HALT);
         cycles   <= cycles   + CNT_W'(state_q != S_IDLE);
         instret  <= instret  + CNT_W'(cpu_en);
         branches <= branches + CNT_W'(cpu_en & branch_taken);
      end
   end

   assign state = state_q;

endmodule
